state_word_writer: RTL and testbench
====================================

Name: state_word_writer

Overview:
- Write-side counterpart of the odd/even word selectors feeding the Skein-1024 mix datapath.
- Accepts mix results as 64-bit word pairs (y0, y1) over a valid/ready handshake and writes them into a 1024-bit state register, pair index 0,2,...,14.
- After 8 pairs, presents the full 1024-bit state to the next round/selector stage and holds it until consumed.

Parameters:
- NUM_WORDS, 16, number of 64-bit words in the state; fixed at 16 for Skein-1024, must be even.
- WORD_W, 64, word width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clear_i  input  1  synchronous clear of index, flags and register contents
- valid_i  input  1  y0_i/y1_i hold a valid word pair
- ready_o  output  1  block accepts a pair this cycle
- y0_i  input  64  even word of the pair (mix output x0')
- y1_i  input  64  odd word of the pair (mix output x1')
- word_o  output  4  even word index the next accepted pair is written to
- full_o  output  1  all 16 words written; register_o valid
- read_i  input  1  consumer has taken register_o; release FULL
- register_o  output  1024  assembled state; word k occupies bits [64k+63:64k]

Behaviour:
- Reset (rst_n low, asynchronous): register_o=0, word_o=0, full_o=0, ready_o=1, state=FILL.
- Two states: FILL and FULL. ready_o = (state==FILL); registered, no combinational path from valid_i.
- FILL, valid_i & ready_o at a clock edge:
  - y0_i is written to word[word_o] and y1_i to word[word_o+1].
  - word_o increments by 2 (4-bit wrap, 14 -> 0).
- Write with word_o==14 moves the state to FULL on that edge. The next cycle has full_o=1, ready_o=0, word_o=0.
- Accept latency: data visible on register_o the cycle after the accepting edge.
- FULL:
  - valid_i is ignored and register_o is held.
  - read_i=1 returns the state to FILL next cycle: full_o=0, ready_o=1, word_o=0.
  - Contents are not cleared; the next fill overwrites them pair by pair.
- read_i in FILL: no effect.
- clear_i (any state): next cycle register_o=0, word_o=0, full_o=0, state=FILL.
  - Priority clear_i > read_i > write.
  - A pair presented on a clear cycle is dropped.
- valid_i with ready_o=0: not accepted. The source must hold the pair (standard valid/ready, no loss).
- Reset asserted mid-fill: immediate return to reset values; partial state is discarded.
- Back-to-back: one pair per cycle sustained in FILL. A full fill takes exactly 8 accepting cycles.

Optional Feature:
- Macro: STATE_WORD_PERMUTE_EN.
- Defined: each word is written through the Threefish-1024 inverse permutation.
  - Input word i lands at register position q(i).
  - q = {0:0, 1:15, 2:2, 3:11, 4:6, 5:13, 6:4, 7:9, 8:14, 9:1, 10:8, 11:5, 12:10, 13:3, 14:12, 15:7}.
  - Result: register_o word j = mix output word pi(j), with pi = {0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1}.
  - word_o still reports the unpermuted input index.
- Undefined: identity placement (word i at position i).
- Handshake and timing are identical in both builds.

Test Plan:
- Reset then 8 back-to-back pairs, y0=64'h(2k), y1=64'h(2k+1), k=0..7.
  - Identity build: full_o=1 exactly one cycle after the 8th accept; word k of register_o = k; ready_o=0; word_o=0.
- FULL with valid_i held high for 5 cycles using y0=64'hDEAD: register_o unchanged, ready_o=0. Then read_i pulse -> full_o=0 and ready_o=1 next cycle.
- Gapped valid_i (valid every 3rd cycle): word_o steps 0,2,...,14 only on accepts; the result matches the back-to-back case.
- After 3 pairs (word_o=6), assert clear_i with valid_i=1 -> next cycle register_o=0, word_o=0, pair dropped.
  - Also: clear_i and read_i together in FULL -> cleared (register_o=0).
- Drop rst_n asynchronously mid-cycle after 5 pairs -> outputs at reset values before the next edge; refill succeeds.
- STATE_WORD_PERMUTE_EN build, same stimulus as test 1 -> register_o word j = pi(j).
  - Word 1 = 9, word 3 = 13, word 15 = 1.

Source files
------------

// File: rtl/state_word_writer.sv
// Assembles 64-bit mix output pairs into the 1024-bit Skein-1024 state and holds it until read.
// Optional build macro STATE_WORD_PERMUTE_EN places words through the Threefish-1024 inverse permutation.
module state_word_writer #(
   parameter int NUM_WORDS = 16,
   parameter int WORD_W    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [WORD_W-1:0]             y0_i,
   input  logic [WORD_W-1:0]             y1_i,
   output logic [3:0]                    word_o,
   output logic                          full_o,
   input  logic                          read_i,
   output logic [NUM_WORDS*WORD_W-1:0]   register_o
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 2);

   typedef enum logic {FILL, FULL} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WORD_W-1:0]  words_q [NUM_WORDS];
   logic               accept;
   logic [IDX_W-1:0]   idx_odd;

   // Register position for mix output word i.
   function automatic logic [IDX_W-1:0] place(input logic [IDX_W-1:0] i);
`ifdef STATE_WORD_PERMUTE_EN
      logic [IDX_W-1:0] p;
      case (i)
         4'd0:    p = 4'd0;
         4'd1:    p = 4'd15;
         4'd2:    p = 4'd2;
         4'd3:    p = 4'd11;
         4'd4:    p = 4'd6;
         4'd5:    p = 4'd13;
         4'd6:    p = 4'd4;
         4'd7:    p = 4'd9;
         4'd8:    p = 4'd14;
         4'd9:    p = 4'd1;
         4'd10:   p = 4'd8;
         4'd11:   p = 4'd5;
         4'd12:   p = 4'd10;
         4'd13:   p = 4'd3;
         4'd14:   p = 4'd12;
         default: p = 4'd7;
      endcase
      return p;
`else
      return i;
`endif
   endfunction

   assign accept  = valid_i && (state_q == FILL) && !clear_i;
   assign idx_odd = {idx_q[IDX_W-1:1], 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Priority: clear, then release on read, then accept a pair.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (clear_i) begin
         state_d = FILL;
         idx_d   = '0;
      end else if (state_q == FULL) begin
         if (read_i) begin
            state_d = FILL;
            idx_d   = '0;
         end
      end else if (valid_i) begin
         idx_d = idx_q + IDX_W'(2);
         if (idx_q == LAST_IDX) state_d = FULL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_WORDS; k++) words_q[k] <= '0;
      end else if (clear_i) begin
         for (int k = 0; k < NUM_WORDS; k++) words_q[k] <= '0;
      end else if (accept) begin
         words_q[place(idx_q)]   <= y0_i;
         words_q[place(idx_odd)] <= y1_i;
      end
   end

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
      assign register_o[g*WORD_W +: WORD_W] = words_q[g];
   end

   assign ready_o = (state_q == FILL);
   assign full_o  = (state_q == FULL);
   assign word_o  = 4'(idx_q);

endmodule

// File: tb/tb_state_word_writer.sv
// Randomized self-checking bench for state_word_writer against a pair-count reference model.
module tb_state_word_writer;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clear_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          read_i = 1'b0;
   logic [63:0]   y0_i = '0;
   logic [63:0]   y1_i = '0;
   logic          ready_o;
   logic [3:0]    word_o;
   logic          full_o;
   logic [1023:0] register_o;

   int vectors = 0;
   int miscompares = 0;

   // Model: mix output words in input order plus number of pairs accepted so far.
   logic [63:0] m_words [16];
   int          m_count = 0;
`ifdef STATE_WORD_PERMUTE_EN
   int src_of [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};
`else
   int src_of [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

   state_word_writer dut (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_o),
      .y0_i(y0_i), .y1_i(y1_i), .word_o(word_o), .full_o(full_o), .read_i(read_i),
      .register_o(register_o)
   );

   always #5 clk = ~clk;

   function automatic logic [1023:0] exp_reg();
      logic [1023:0] r;
      for (int j = 0; j < 16; j++) r[64*j +: 64] = m_words[src_of[j]];
      return r;
   endfunction

   function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
      for (int j = 0; j < 16; j++) if (a[64*j +: 64] !== b[64*j +: 64]) return j;
      return 0;
   endfunction

   function automatic logic [3:0] exp_word();
      return 4'((m_count * 2) % 16);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_words[i] = '0;
      m_count = 0;
   endtask

   // Applies one cycle of inputs, advances the model at the edge, returns at edge+1.
   task automatic cycle(input logic c, input logic v, input logic r,
                        input logic [63:0] a, input logic [63:0] b);
      clear_i = c; valid_i = v; read_i = r; y0_i = a; y1_i = b;
      @(posedge clk);
      if (c) begin
         model_reset();
      end else if (m_count == 8) begin
         if (r) m_count = 0;
      end else if (v) begin
         m_words[2*m_count]   = a;
         m_words[2*m_count+1] = b;
         m_count++;
      end
      #1;
      clear_i = 1'b0; valid_i = 1'b0; read_i = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if (register_o !== '0) begin
         miscompares++;
         $display("FAIL reset_reg: word %0d got %h expected 0", first_diff(register_o, '0),
                  register_o[64*first_diff(register_o, '0) +: 64]);
      end
      vectors++;
      if ({ready_o, full_o, word_o} !== {1'b1, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL reset_ctrl: got ready=%b full=%b word=%0d expected 1 0 0", ready_o, full_o, word_o);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if ({ready_o, word_o} !== {1'b1, 4'(2*k)}) begin
            miscompares++;
            $display("FAIL b2b_step: got ready=%b word=%0d expected 1 %0d", ready_o, word_o, 2*k);
         end
         cycle(1'b0, 1'b1, 1'b0, 64'(2*k), 64'(2*k+1));
      end
      vectors++;
      if ({full_o, ready_o, word_o} !== {1'b1, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL b2b_full: got full=%b ready=%b word=%0d expected 1 0 0", full_o, ready_o, word_o);
      end
      vectors++;
      if (register_o !== exp_reg()) begin
         miscompares++;
         $display("FAIL b2b_reg: word %0d got %h expected %h", first_diff(register_o, exp_reg()),
                  register_o[64*first_diff(register_o, exp_reg()) +: 64],
                  exp_reg()[64*first_diff(register_o, exp_reg()) +: 64]);
      end
`ifdef STATE_WORD_PERMUTE_EN
      vectors++;
      if ({register_o[64 +: 64], register_o[192 +: 64], register_o[960 +: 64]} !== {64'd9, 64'd13, 64'd1}) begin
         miscompares++;
         $display("FAIL b2b_perm: got w1=%0h w3=%0h w15=%0h expected 9 d 1",
                  register_o[64 +: 64], register_o[192 +: 64], register_o[960 +: 64]);
      end
`else
      for (int k = 0; k < 16; k++) begin
         vectors++;
         if (register_o[64*k +: 64] !== 64'(k)) begin
            miscompares++;
            $display("FAIL b2b_word%0d: got %h expected %h", k, register_o[64*k +: 64], 64'(k));
         end
      end
`endif
   endtask

   task automatic test_full_hold();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 64'hDEAD, 64'hDEAD);
         vectors++;
         if ({full_o, ready_o} !== 2'b10 || register_o !== exp_reg()) begin
            miscompares++;
            $display("FAIL hold_%0d: got full=%b ready=%b word %0d=%h expected full=1 ready=0 word=%h", i,
                     full_o, ready_o, first_diff(register_o, exp_reg()),
                     register_o[64*first_diff(register_o, exp_reg()) +: 64],
                     exp_reg()[64*first_diff(register_o, exp_reg()) +: 64]);
         end
      end
      cycle(1'b0, 1'b0, 1'b1, '0, '0);
      vectors++;
      if ({full_o, ready_o, word_o} !== {1'b0, 1'b1, 4'd0}) begin
         miscompares++;
         $display("FAIL hold_read: got full=%b ready=%b word=%0d expected 0 1 0", full_o, ready_o, word_o);
      end
   endtask

   task automatic test_gapped();
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, '0);
         cycle(1'b0, 1'b0, 1'b1, '0, '0);
         vectors++;
         if ({word_o, full_o} !== {4'(2*k), 1'b0}) begin
            miscompares++;
            $display("FAIL gap_idle%0d: got word=%0d full=%b expected %0d 0", k, word_o, full_o, 2*k);
         end
         cycle(1'b0, 1'b1, 1'b0, 64'(2*k), 64'(2*k+1));
      end
      vectors++;
      if ({full_o, word_o} !== {1'b1, 4'd0} || register_o !== exp_reg()) begin
         miscompares++;
         $display("FAIL gap_result: got full=%b word=%0d word %0d=%h expected full=1 word=0 %h", full_o, word_o,
                  first_diff(register_o, exp_reg()), register_o[64*first_diff(register_o, exp_reg()) +: 64],
                  exp_reg()[64*first_diff(register_o, exp_reg()) +: 64]);
      end
      cycle(1'b0, 1'b0, 1'b1, '0, '0);
   endtask

   task automatic test_clear();
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      vectors++;
      if (word_o !== 4'd6) begin
         miscompares++;
         $display("FAIL clr_pre: got word=%0d expected 6", word_o);
      end
      cycle(1'b1, 1'b1, 1'b0, 64'hBAD, 64'hBAD);
      vectors++;
      if ({register_o !== '0, word_o, full_o, ready_o} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL clr_fill: got word=%0d full=%b ready=%b regzero=%b expected 0 0 1 1",
                  word_o, full_o, ready_o, register_o == '0);
      end
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      cycle(1'b1, 1'b0, 1'b1, '0, '0);
      vectors++;
      if ({register_o !== '0, full_o, ready_o} !== {1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL clr_full: got full=%b ready=%b regzero=%b expected 0 1 1",
                  full_o, ready_o, register_o == '0);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({register_o !== '0, word_o, full_o, ready_o} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL arst: got word=%0d full=%b ready=%b regzero=%b expected 0 0 1 1",
                  word_o, full_o, ready_o, register_o == '0);
      end
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      vectors++;
      if (full_o !== 1'b1 || register_o !== exp_reg()) begin
         miscompares++;
         $display("FAIL arst_refill: got full=%b word %0d=%h expected full=1 %h", full_o,
                  first_diff(register_o, exp_reg()), register_o[64*first_diff(register_o, exp_reg()) +: 64],
                  exp_reg()[64*first_diff(register_o, exp_reg()) +: 64]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               {$urandom, $urandom}, {$urandom, $urandom});
         vectors++;
         if ({ready_o, full_o, word_o} !== {m_count < 8, m_count == 8, exp_word()} ||
             register_o !== exp_reg()) begin
            miscompares++;
            $display("FAIL rand_%0d: got ready=%b full=%b word=%0d w%0d=%h expected %b %b %0d %h", n,
                     ready_o, full_o, word_o, first_diff(register_o, exp_reg()),
                     register_o[64*first_diff(register_o, exp_reg()) +: 64],
                     m_count < 8, m_count == 8, exp_word(),
                     exp_reg()[64*first_diff(register_o, exp_reg()) +: 64]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_full_hold();
      test_gapped();
      test_clear();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
